// File: rtl/power_pkg.sv
// Shared types and constants for the power-management monitor.
package power_pkg;

  localparam int PM_MAX_CH = 8;
  localparam int PM_MUX_W  = 3;

  typedef enum logic [1:0] {
    PM_IDLE   = 2'd0,
    PM_SETTLE = 2'd1,
    PM_SAMPLE = 2'd2,
    PM_NEXT   = 2'd3
  } pm_state_t;

endpackage

// File: rtl/power_monitor_sequencer_sync2.sv
// Generic two-flop synchronizer for asynchronous pin inputs.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture; first stage may go metastable, second is clean.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/power_monitor_sequencer.sv
// Power-board monitor: walks the analog mux, samples the comparator line
// after a settle delay, tracks consecutive faults per channel and drives
// the kill switch that gates motor/GPIO outputs.
//
// Handshake note: arm and kill_req are single-cycle request pulses from the
// bus slave; there is no ready/ack, each pulse is acted on in the cycle it
// is high. status_valid is a single-cycle pulse with no back-pressure.
module power_monitor_sequencer
  import power_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int SETTLE_CYCLES = 5000,
  parameter int FAULT_COUNT   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                data_in,
  input  logic                arm,
  input  logic                kill_req,
  output logic [PM_MUX_W-1:0] mux_out,
  output logic                kill_sw,
  output logic [NUM_CH-1:0]   status,
  output logic                status_valid,
  output logic [PM_MUX_W-1:0] fault_ch,
  output logic                tripped,
  output pm_state_t           dbg_state
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PM_MUX_W-1:0] CH_LAST  = PM_MUX_W'(NUM_CH - 1);
  localparam logic [3:0]          FC_SAT   = 4'(FAULT_COUNT);

  pm_state_t             state_q, state_d;
  logic [PM_MUX_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_CH-1:0]     status_q, status_d;
  logic [3:0]            fcnt_q [NUM_CH];
  logic [3:0]            fcnt_d [NUM_CH];
  logic                  kill_q, kill_d;
  logic                  tripped_q, tripped_d;
  logic [PM_MUX_W-1:0]   fault_ch_c;

  logic data_s;
  logic sample_en;
  logic arm_clear;
  logic sat_now;
  logic any_sat;

  sync2 #(.W(1)) u_data_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (data_in),
    .q_o     (data_s)
  );

  assign sample_en = enable && (state_q == PM_SAMPLE);
  assign arm_clear = arm && tripped_q;

  // Scan FSM: channel select and settle counter. Dropping enable aborts the
  // sweep from any state and rewinds to channel 0.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = PM_IDLE;
      ch_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        PM_IDLE: begin
          ch_d    = '0;
          cnt_d   = '0;
          state_d = PM_SETTLE;
        end
        PM_SETTLE: begin
          if (cnt_q == CNT_LAST) state_d = PM_SAMPLE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        PM_SAMPLE: state_d = PM_NEXT;
        PM_NEXT: begin
          cnt_d   = '0;
          state_d = PM_SETTLE;
          ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
        end
        default: state_d = PM_IDLE;
      endcase
    end
  end

  // Sample capture and per-channel fault counters. A clearing arm is applied
  // first so a bad sample in the same cycle still counts afterwards.
  always_comb begin
    logic [3:0] base;
    base     = '0;
    status_d = status_q;
    sat_now  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      base      = arm_clear ? 4'd0 : fcnt_q[i];
      fcnt_d[i] = base;
      if (sample_en && (ch_q == PM_MUX_W'(i))) begin
        status_d[i] = data_s;
        if (!data_s) begin
          if (base != FC_SAT)          fcnt_d[i] = base + 4'd1;
          if (base == FC_SAT - 4'd1)   sat_now   = 1'b1;
        end else begin
          fcnt_d[i] = '0;
        end
      end
    end
  end

  // Protection: saturation detect, lowest faulting channel, trip latch and
  // kill switch. Trip and kill_req dominate arm; arm cannot raise kill_sw in
  // the very cycle a sample saturates a counter.
  always_comb begin
    any_sat    = 1'b0;
    fault_ch_c = '0;
    tripped_d  = tripped_q;
    kill_d     = kill_q;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fcnt_q[i] == FC_SAT) begin
        any_sat    = 1'b1;
        fault_ch_c = PM_MUX_W'(i);
      end
    end
    if (arm_clear)    tripped_d = 1'b0;
    else if (any_sat) tripped_d = 1'b1;
    if (any_sat || kill_req)                  kill_d = 1'b0;
    else if (arm && !tripped_q && !sat_now)   kill_d = 1'b1;
  end

  // State register for FSM, datapath and protection latches.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= PM_IDLE;
      ch_q      <= '0;
      cnt_q     <= '0;
      status_q  <= '0;
      kill_q    <= 1'b0;
      tripped_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) fcnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      kill_q    <= kill_d;
      tripped_q <= tripped_d;
      for (int i = 0; i < NUM_CH; i++) fcnt_q[i] <= fcnt_d[i];
    end
  end

  assign mux_out      = ch_q;
  assign kill_sw      = kill_q;
  assign status       = status_q;
  assign status_valid = (state_q == PM_NEXT) && (ch_q == CH_LAST);
  assign fault_ch     = fault_ch_c;
  assign tripped      = tripped_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_power_monitor_sequencer.sv
// Directed bench for power_monitor_sequencer (4 channels, settle 4, trip at 3).
module tb_power_monitor_sequencer;
  import power_pkg::*;

  localparam int NUM_CH = 4;
  localparam int SETTLE = 4;
  localparam int FC     = 3;

  logic            clk = 1'b0;
  logic            reset_n, enable, data_in, arm, kill_req;
  logic [2:0]      mux_out;
  logic            kill_sw;
  logic [3:0]      status;
  logic            status_valid;
  logic [2:0]      fault_ch;
  logic            tripped;
  pm_state_t       dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int e0    = 0;

  typedef struct {
    int         at;
    logic       din;
    logic [2:0] mux;
    logic       sv;
    logic [3:0] st;
    logic       kill;
    pm_state_t  state;
  } vec_t;

  vec_t vecs[13];

  power_monitor_sequencer #(
    .NUM_CH        (NUM_CH),
    .SETTLE_CYCLES (SETTLE),
    .FAULT_COUNT   (FC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .data_in      (data_in),
    .arm          (arm),
    .kill_req     (kill_req),
    .mux_out      (mux_out),
    .kill_sw      (kill_sw),
    .status       (status),
    .status_valid (status_valid),
    .fault_ch     (fault_ch),
    .tripped      (tripped),
    .dbg_state    (dbg_state)
  );

  // clock
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_mux_enter(input logic [2:0] v);
    int   n;
    logic ok;
    n = 0;
    while (mux_out == v && n < 100) begin tick(); n++; end
    while (mux_out != v && n < 200) begin tick(); n++; end
    ok = (mux_out == v);
    check("wait_mux_enter", 32'(ok), 32'd1);
  endtask

  // Visit channel c: drive data_in bad/good while it is selected, stop one
  // cycle after its sample edge (data_in still driven).
  task automatic fault_visit(input logic [2:0] c, input logic bad, input logic pulse_arm);
    logic [3:0] sh;
    logic       sb, expb;
    wait_mux_enter(c);
    data_in = ~bad;
    repeat (4) tick();
    check("visit_sample_state", 32'(dbg_state), 32'(PM_SAMPLE));
    arm = pulse_arm;
    tick();
    arm = 1'b0;
    sh   = status >> c;
    sb   = sh[0];
    expb = ~bad;
    check("visit_status_bit", 32'(sb), 32'(expb));
  endtask

  task automatic pulse(input logic a, input logic k);
    arm      = a;
    kill_req = k;
    tick();
    arm      = 1'b0;
    kill_req = 1'b0;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic pat[6];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    vecs[0]  = '{1,  1'b1, 3'd0, 1'b0, 4'b0000, 1'b0, PM_SETTLE};
    vecs[1]  = '{5,  1'b1, 3'd0, 1'b0, 4'b0000, 1'b0, PM_SAMPLE};
    vecs[2]  = '{6,  1'b1, 3'd0, 1'b0, 4'b0001, 1'b0, PM_NEXT};
    vecs[3]  = '{7,  1'b1, 3'd1, 1'b0, 4'b0001, 1'b0, PM_SETTLE};
    vecs[4]  = '{13, 1'b1, 3'd2, 1'b0, 4'b0011, 1'b0, PM_SETTLE};
    vecs[5]  = '{19, 1'b1, 3'd3, 1'b0, 4'b0111, 1'b0, PM_SETTLE};
    vecs[6]  = '{23, 1'b1, 3'd3, 1'b0, 4'b0111, 1'b0, PM_SAMPLE};
    vecs[7]  = '{24, 1'b1, 3'd3, 1'b1, 4'b1111, 1'b0, PM_NEXT};
    vecs[8]  = '{25, 1'b1, 3'd0, 1'b0, 4'b1111, 1'b0, PM_SETTLE};
    vecs[9]  = '{31, 1'b1, 3'd1, 1'b0, 4'b1111, 1'b0, PM_SETTLE};
    vecs[10] = '{47, 1'b1, 3'd3, 1'b0, 4'b1111, 1'b0, PM_SAMPLE};
    vecs[11] = '{48, 1'b1, 3'd3, 1'b1, 4'b1111, 1'b0, PM_NEXT};
    vecs[12] = '{49, 1'b1, 3'd0, 1'b0, 4'b1111, 1'b0, PM_SETTLE};

    // reset
    reset_n  = 1'b0;
    enable   = 1'b0;
    data_in  = 1'b1;
    arm      = 1'b0;
    kill_req = 1'b0;
    repeat (3) tick();
    check("rst_mux",     32'(mux_out),      32'd0);
    check("rst_kill",    32'(kill_sw),      32'd0);
    check("rst_status",  32'(status),       32'd0);
    check("rst_sv",      32'(status_valid), 32'd0);
    check("rst_fault",   32'(fault_ch),     32'd0);
    check("rst_tripped", 32'(tripped),      32'd0);
    check("rst_state",   32'(dbg_state),    32'(PM_IDLE));
    reset_n = 1'b1;
    tick();
    check("idle_hold_state", 32'(dbg_state), 32'(PM_IDLE));

    // Table: first two sweeps, all channels good.
    enable = 1'b1;
    e0     = cyc;
    for (int i = 0; i < 13; i++) begin
      while (cyc - e0 < vecs[i].at) tick();
      data_in = vecs[i].din;
      check("vec_mux",    32'(mux_out),      32'(vecs[i].mux));
      check("vec_sv",     32'(status_valid), 32'(vecs[i].sv));
      check("vec_status", 32'(status),       32'(vecs[i].st));
      check("vec_kill",   32'(kill_sw),      32'(vecs[i].kill));
      check("vec_state",  32'(dbg_state),    32'(vecs[i].state));
    end

    // Arm with everything healthy.
    pulse(1'b1, 1'b0);
    check("arm_ok_kill",    32'(kill_sw), 32'd1);
    check("arm_ok_tripped", 32'(tripped), 32'd0);

    // Channel 2 bad for three sweeps -> trip exactly one cycle after third sample.
    for (int s = 0; s < 3; s++) begin
      fault_visit(3'd2, 1'b1, 1'b0);
      check("ch2_status",       32'(status),  32'(4'b1011));
      check("ch2_kill_at_samp", 32'(kill_sw), 32'd1);
      check("ch2_trip_at_samp", 32'(tripped), 32'd0);
      data_in = 1'b1;
      tick();
      if (s < 2) begin
        check("ch2_kill_pre", 32'(kill_sw), 32'd1);
        check("ch2_trip_pre", 32'(tripped), 32'd0);
      end else begin
        check("ch2_kill_trip",  32'(kill_sw),  32'd0);
        check("ch2_tripped",    32'(tripped),  32'd1);
        check("ch2_fault_ch",   32'(fault_ch), 32'd2);
      end
    end

    // Recovery needs two arms; kill_req alone and with arm kills.
    pulse(1'b1, 1'b0);
    check("arm1_tripped", 32'(tripped),  32'd0);
    check("arm1_kill",    32'(kill_sw),  32'd0);
    check("arm1_fault",   32'(fault_ch), 32'd0);
    pulse(1'b1, 1'b0);
    check("arm2_kill",    32'(kill_sw),  32'd1);
    pulse(1'b0, 1'b1);
    check("kreq_kill",    32'(kill_sw),  32'd0);
    check("kreq_tripped", 32'(tripped),  32'd0);
    pulse(1'b1, 1'b0);
    check("rearm_kill",   32'(kill_sw),  32'd1);
    pulse(1'b1, 1'b1);
    check("kreq_arm_kill",    32'(kill_sw), 32'd0);
    check("kreq_arm_tripped", 32'(tripped), 32'd0);

    // Channel 3 trips with arm landing on the saturating sample edge.
    for (int s = 0; s < 3; s++) begin
      fault_visit(3'd3, 1'b1, (s == 2));
      check("ch3_status",  32'(status),  32'(4'b0111));
      check("ch3_kill_samp", 32'(kill_sw), 32'd0);
      data_in = 1'b1;
      tick();
      if (s == 2) begin
        check("ch3_kill_after", 32'(kill_sw),  32'd0);
        check("ch3_tripped",    32'(tripped),  32'd1);
        check("ch3_fault_ch",   32'(fault_ch), 32'd3);
      end
    end
    pulse(1'b1, 1'b0);
    check("ch3_arm1_tripped", 32'(tripped), 32'd0);
    pulse(1'b1, 1'b0);
    check("ch3_arm2_kill",    32'(kill_sw), 32'd1);

    // Channel 1: bad, bad, good, bad, bad, good -> counter restarts, no trip.
    for (int s = 0; s < 6; s++) begin
      fault_visit(3'd1, pat[s], 1'b0);
      check("ch1_kill_samp", 32'(kill_sw), 32'd1);
      data_in = 1'b1;
      tick();
      check("ch1_kill_after",    32'(kill_sw), 32'd1);
      check("ch1_tripped_after", 32'(tripped), 32'd0);
    end
    check("ch1_status_final", 32'(status), 32'(4'b1111));

    // Drop enable during SETTLE of channel 2, then restart from channel 0.
    wait_mux_enter(3'd2);
    repeat (2) tick();
    check("en_settle_state", 32'(dbg_state), 32'(PM_SETTLE));
    enable = 1'b0;
    tick();
    check("dis_state",  32'(dbg_state), 32'(PM_IDLE));
    check("dis_mux",    32'(mux_out),   32'd0);
    check("dis_status", 32'(status),    32'(4'b1111));
    check("dis_kill",   32'(kill_sw),   32'd1);
    repeat (3) tick();
    check("dis_hold_state", 32'(dbg_state), 32'(PM_IDLE));
    enable = 1'b1;
    tick();
    check("reen_state", 32'(dbg_state), 32'(PM_SETTLE));
    check("reen_mux",   32'(mux_out),   32'd0);
    repeat (4) tick();
    check("reen_sample", 32'(dbg_state), 32'(PM_SAMPLE));
    check("reen_mux0",   32'(mux_out),   32'd0);
    repeat (2) tick();
    check("reen_mux1",   32'(mux_out),   32'd1);

    // Reset asserted while in SAMPLE with kill_sw high.
    wait_mux_enter(3'd1);
    repeat (4) tick();
    check("prerst_state", 32'(dbg_state), 32'(PM_SAMPLE));
    check("prerst_kill",  32'(kill_sw),   32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_mux",     32'(mux_out),      32'd0);
    check("mid_rst_kill",    32'(kill_sw),      32'd0);
    check("mid_rst_status",  32'(status),       32'd0);
    check("mid_rst_sv",      32'(status_valid), 32'd0);
    check("mid_rst_fault",   32'(fault_ch),     32'd0);
    check("mid_rst_tripped", 32'(tripped),      32'd0);
    check("mid_rst_state",   32'(dbg_state),    32'(PM_IDLE));
    reset_n = 1'b1;
    enable  = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
